// File: rtl/rr5_pkg.sv
// Shared definitions for the five-requester round-robin arbiter.
package rr5_pkg;

  localparam int         N_REQ   = 5;
  localparam logic [2:0] ID_NONE = 3'b111;

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_e;

  // Modulo-5 increment of a requester index (0..4 wraps to 0).
  function automatic logic [2:0] rot_next(input logic [2:0] idx);
    return (idx >= 3'd4) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/rr5_pick.sv
// Rotating-priority picker: finds the first set request searching from
// ptr upward, wrapping modulo 5. Purely combinational.
module rr5_pick
  import rr5_pkg::*;
(
  input  logic [4:0] r,
  input  logic [2:0] ptr,
  output logic       valid,
  output logic [2:0] idx
);

  logic [2:0] cand;

  // Walk the five candidates in priority order and keep the first hit.
  always_comb begin
    valid = 1'b0;
    idx   = ID_NONE;
    cand  = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!valid && r[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
      cand = rot_next(cand);
    end
  end

endmodule

// File: rtl/rr_arbiter5.sv
// Five-requester round-robin arbiter with per-bit request polarity,
// registered one-hot grant, release on DONE / withdrawal / hold timeout.
module rr_arbiter5
  import rr5_pkg::*;
#(
  parameter logic [4:0] INV_MASK = 5'b00111,
  parameter logic [7:0] MAX_HOLD = 8'd15
) (
  input  logic       C,
  input  logic       CLR,
  input  logic [4:0] REQ,
  input  logic       DONE,
  output logic [4:0] GNT,
  output logic [2:0] GNT_ID,
  output logic       BUSY,
  output logic       TIMEOUT
);

  state_e     state_q;
  logic [2:0] ptr_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic [4:0] gnt_q;
  logic [2:0] gnt_id_q;
  logic       busy_q;
  logic       timeout_q;

  logic [4:0] r;
  logic       pick_valid;
  logic [2:0] pick_idx;
  logic       owner_req;
  logic       hold_hit;
  logic       release_now;
  logic       timeout_only;

  // Normalise polarity so active-low clients read as active-high.
  assign r = REQ ^ INV_MASK;

  rr5_pick u_pick (
    .r     (r),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Release decision for the current grantee. gnt_q is one-hot while
  // granting, so masking r with it is the same as reading r[GNT_ID].
  always_comb begin
    owner_req    = |(r & gnt_q);
    hold_hit     = (MAX_HOLD != 8'd0) && (cnt_q == MAX_HOLD - 8'd1);
    release_now  = DONE || !owner_req || hold_hit;
    timeout_only = hold_hit && !DONE && owner_req;
    cnt_d        = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  end

  // FSM with pointer, hold counter and all outputs registered.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state_q   <= S_IDLE;
      ptr_q     <= 3'd0;
      cnt_q     <= 8'd0;
      gnt_q     <= 5'd0;
      gnt_id_q  <= ID_NONE;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          timeout_q <= 1'b0;
          if (pick_valid) begin
            gnt_q    <= 5'd1 << pick_idx;
            gnt_id_q <= pick_idx;
            busy_q   <= 1'b1;
            cnt_q    <= 8'd0;
            state_q  <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (release_now) begin
            gnt_q     <= 5'd0;
            gnt_id_q  <= ID_NONE;
            busy_q    <= 1'b0;
            ptr_q     <= rot_next(gnt_id_q);
            timeout_q <= timeout_only;
            state_q   <= S_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign GNT     = gnt_q;
  assign GNT_ID  = gnt_id_q;
  assign BUSY    = busy_q;
  assign TIMEOUT = timeout_q;

endmodule
